// File: rtl/shift_reg_sequencer_if.sv
// Command handshake and shift-register control bundles
// used by shift_reg_sequencer.
interface sr_cmd_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_load,
    output cmd_dir,
    output cmd_count,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_data,
    output cmd_ready
  );
endinterface

interface sr_ctl_if #(
  parameter int WIDTH = 4
);
  logic             sr_load;
  logic             sr_en;
  logic             sr_dir;
  logic [WIDTH-1:0] sr_data;
  logic [WIDTH-1:0] sr_q;

  modport master (
    output sr_load,
    output sr_en,
    output sr_dir,
    output sr_data,
    input  sr_q
  );

  modport slave (
    input  sr_load,
    input  sr_en,
    input  sr_dir,
    input  sr_data,
    output sr_q
  );
endinterface

// File: rtl/shift_reg_sequencer.sv
// Sequencer that turns one load/shift command at a time into
// load, shift-enable and direction strobes for a shift register.
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  sr_cmd_if.slave          cmd,
  sr_ctl_if.master         sr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abt_q, abt_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready;
  logic             ld_stb;
  logic             en_stb;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      abt_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      abt_q     <= abt_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    abt_d     = abt_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    result_d  = result_q;
    ready     = 1'b0;
    ld_stb    = 1'b0;
    en_stb    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          dir_d  = cmd.cmd_dir;
          data_d = cmd.cmd_data;
          cnt_d  = cmd.cmd_count;
          abt_d  = 1'b0;
          if (cmd.cmd_load)
            state_d = S_LOAD;
          else if (cmd.cmd_count != '0)
            state_d = S_SHIFT;
          else
            state_d = S_DONE;
        end
      end
      S_LOAD: begin
        // abort suppresses the strobe in the same cycle
        if (abort) begin
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ld_stb  = 1'b1;
          state_d = (cnt_q != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          abt_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          en_stb = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1))
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        aborted_d = abt_q;
        result_d  = sr.sr_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd.cmd_ready = ready;
  assign sr.sr_load    = ld_stb;
  assign sr.sr_en      = en_stb;
  assign sr.sr_dir     = dir_q;
  assign sr.sr_data    = data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign result        = result_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: a behavioural shift register
// plant plus an arithmetic command model.
module tb_shift_reg_sequencer;
  localparam int W  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         abort;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [W-1:0] result;
  logic [W-1:0] plant_q;
  logic [W-1:0] mdl_val;
  int n_cmp = 0;
  int n_bad = 0;

  sr_cmd_if #(.WIDTH(W), .CNT_W(CW)) cmd_bus ();
  sr_ctl_if #(.WIDTH(W)) ctl_bus ();

  shift_reg_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .cmd    (cmd_bus),
    .sr     (ctl_bus),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .aborted(aborted),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ctl_bus.sr_load)
      plant_q <= ctl_bus.sr_data;
    else if (ctl_bus.sr_en)
      plant_q <= ctl_bus.sr_dir ? (plant_q << 1) : (plant_q >> 1);
  end
  assign ctl_bus.sr_q = plant_q;

  // k = index of the active (load/shift) cycle carrying abort, -1 = none
  function automatic void model(
    input  logic [W-1:0] start, input bit ld, input bit dir,
    input  int n, input int k, input logic [W-1:0] data,
    output logic [W-1:0] res, output int lat, output bit abt,
    output int nld, output int nsh);
    int active;
    int v;
    active = int'(ld) + n;
    abt = (k >= 0) && (k < active);
    if (abt) active = k + 1;
    nld = (ld && (!abt || k > 0)) ? 1 : 0;
    nsh = abt ? ((k >= int'(ld)) ? k - int'(ld) : 0) : n;
    v = nld ? int'(data) : int'(start);
    for (int i = 0; i < nsh; i++)
      v = dir ? (v * 2) % (1 << W) : v / 2;
    res = W'(v);
    lat = active + 2;
  endfunction

  // Called in the low phase; returns #1 after the negedge of the done cycle.
  task automatic run_cmd(
    input  bit ld, input bit dir, input int n,
    input  logic [W-1:0] data, input int k, input bit hold,
    output int lat, output logic [W-1:0] res, output logic abt,
    output int nld, output int nsh, output int perr, output int waited);
    lat = -1; res = 'x; abt = 1'bx;
    nld = 0; nsh = 0; perr = 0; waited = 0;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_load  = ld;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_count = CW'(n);
    cmd_bus.cmd_data  = data;
    abort = 1'b0;
    while (cmd_bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited < 20) begin
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        cmd_bus.cmd_valid = hold;
        if (hold) cmd_bus.cmd_data = ~data;
        abort = (c == k + 1);
        #1;
        if (done === 1'b1) begin
          lat = c; res = result; abt = aborted;
          if (busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1) perr++;
          break;
        end
        if (busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0) perr++;
        if (ctl_bus.sr_load === 1'b1) begin
          nld++;
          if (ctl_bus.sr_data !== data) perr++;
        end
        if (ctl_bus.sr_en === 1'b1) begin
          nsh++;
          if (ctl_bus.sr_dir !== dir) perr++;
        end
      end
    end else perr++;
    cmd_bus.cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; abort = 1'b0;
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_load = 1'b0;
    cmd_bus.cmd_dir = 1'b0; cmd_bus.cmd_count = '0;
    cmd_bus.cmd_data = '0;
    plant_q = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({cmd_bus.cmd_ready, busy, done, aborted} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 1000",
               {cmd_bus.cmd_ready, busy, done, aborted});
    end
    n_cmp++;
    if ({ctl_bus.sr_load, ctl_bus.sr_en, ctl_bus.sr_dir} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 000",
               {ctl_bus.sr_load, ctl_bus.sr_en, ctl_bus.sr_dir});
    end
    n_cmp++;
    if (ctl_bus.sr_data !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_sr_data got %b want 0000", ctl_bus.sr_data);
    end
    n_cmp++;
    if (result !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_result got %b want 0000", result);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({cmd_bus.cmd_ready, busy, ctl_bus.sr_load, ctl_bus.sr_en, done}
          !== 5'b10000) begin
        n_bad++;
        $display("FAIL idle_%0d got %b want 10000", i,
                 {cmd_bus.cmd_ready, busy, ctl_bus.sr_load, ctl_bus.sr_en, done});
      end
    end
  endtask

  task automatic test_load_shift_right();
    int lat, nld, nsh, perr, wt;
    logic [W-1:0] res;
    logic abt;
    run_cmd(1, 0, 1, 4'b1010, -1, 0, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (lat !== 4 || res !== 4'b0101 || abt !== 1'b0) begin
      n_bad++;
      $display("FAIL load_right got lat=%0d res=%b ab=%b want 4 0101 0",
               lat, res, abt);
    end
    n_cmp++;
    if (nld !== 1 || nsh !== 1 || perr !== 0) begin
      n_bad++;
      $display("FAIL load_right_strobes got ld=%0d sh=%0d err=%0d want 1 1 0",
               nld, nsh, perr);
    end
    mdl_val = 4'b0101;
  endtask

  task automatic test_shift_left();
    int lat, nld, nsh, perr, wt;
    logic [W-1:0] res;
    logic abt;
    @(negedge clk); #1;
    run_cmd(0, 1, 2, 4'b0000, -1, 0, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (lat !== 4 || res !== 4'b0100 || abt !== 1'b0) begin
      n_bad++;
      $display("FAIL shift_left got lat=%0d res=%b ab=%b want 4 0100 0",
               lat, res, abt);
    end
    n_cmp++;
    if (nld !== 0 || nsh !== 2 || perr !== 0) begin
      n_bad++;
      $display("FAIL shift_left_strobes got ld=%0d sh=%0d err=%0d want 0 2 0",
               nld, nsh, perr);
    end
    mdl_val = 4'b0100;
  endtask

  task automatic test_load_count0_held();
    int lat, nld, nsh, perr, wt;
    logic [W-1:0] res;
    logic abt;
    @(negedge clk); #1;
    run_cmd(1, 0, 0, 4'b1011, -1, 1, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (lat !== 3 || res !== 4'b1011 || abt !== 1'b0) begin
      n_bad++;
      $display("FAIL load_cnt0 got lat=%0d res=%b ab=%b want 3 1011 0",
               lat, res, abt);
    end
    n_cmp++;
    if (nld !== 1 || nsh !== 0 || perr !== 0) begin
      n_bad++;
      $display("FAIL load_cnt0_strobes got ld=%0d sh=%0d err=%0d want 1 0 0",
               nld, nsh, perr);
    end
    mdl_val = 4'b1011;
  endtask

  task automatic test_abort_back_to_back();
    int lat, nld, nsh, perr, wt;
    logic [W-1:0] res;
    logic abt;
    @(negedge clk); #1;
    run_cmd(1, 0, 7, 4'b1111, 2, 0, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (lat !== 5 || res !== 4'b0111 || abt !== 1'b1) begin
      n_bad++;
      $display("FAIL abort got lat=%0d res=%b ab=%b want 5 0111 1",
               lat, res, abt);
    end
    n_cmp++;
    if (nld !== 1 || nsh !== 1 || perr !== 0) begin
      n_bad++;
      $display("FAIL abort_strobes got ld=%0d sh=%0d err=%0d want 1 1 0",
               nld, nsh, perr);
    end
    run_cmd(0, 1, 0, 4'b0000, -1, 0, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (wt !== 0 || lat !== 2 || res !== 4'b0111 || abt !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b got wait=%0d lat=%0d res=%b ab=%b want 0 2 0111 0",
               wt, lat, res, abt);
    end
    mdl_val = 4'b0111;
  endtask

  task automatic test_reset_mid();
    int lat, nld, nsh, perr, wt;
    int seen_done;
    logic [W-1:0] res;
    logic abt;
    @(negedge clk); #1;
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_load = 1'b0;
    cmd_bus.cmd_dir = 1'b1; cmd_bus.cmd_count = 3'd5;
    cmd_bus.cmd_data = 4'b1001;
    @(posedge clk);
    @(negedge clk); cmd_bus.cmd_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (ctl_bus.sr_en !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_shift got en=%b busy=%b want 1 1",
               ctl_bus.sr_en, busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cmd_bus.cmd_ready, busy, ctl_bus.sr_load, ctl_bus.sr_en,
         ctl_bus.sr_dir, done, aborted} !== 7'b1000000 ||
        ctl_bus.sr_data !== 4'b0000 || result !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset got %b data=%b res=%b want 1000000 0000 0000",
               {cmd_bus.cmd_ready, busy, ctl_bus.sr_load, ctl_bus.sr_en,
                ctl_bus.sr_dir, done, aborted}, ctl_bus.sr_data, result);
    end
    @(negedge clk); reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++;
      $display("FAIL mid_no_done got %0d active cycles want 0", seen_done);
    end
    run_cmd(1, 0, 0, 4'b0110, -1, 0, lat, res, abt, nld, nsh, perr, wt);
    n_cmp++;
    if (lat !== 3 || res !== 4'b0110 || abt !== 1'b0 || perr !== 0) begin
      n_bad++;
      $display("FAIL after_reset got lat=%0d res=%b ab=%b err=%0d want 3 0110 0 0",
               lat, res, abt, perr);
    end
    mdl_val = 4'b0110;
  endtask

  task automatic test_random();
    int lat, nld, nsh, perr, wt;
    int e_lat, e_nld, e_nsh, n, k;
    logic [W-1:0] res, e_res, data;
    logic abt;
    bit e_abt, ld, dir;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      ld   = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      n    = int'($urandom_range(0, 7));
      data = W'($urandom);
      k    = -1;
      if ($urandom_range(0, 3) == 0 && int'(ld) + n > 0)
        k = int'($urandom_range(0, int'(ld) + n - 1));
      model(mdl_val, ld, dir, n, k, data, e_res, e_lat, e_abt, e_nld, e_nsh);
      run_cmd(ld, dir, n, data, k, 0, lat, res, abt, nld, nsh, perr, wt);
      n_cmp++;
      if (lat !== e_lat) begin
        n_bad++;
        $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, e_lat);
      end
      n_cmp++;
      if (res !== e_res) begin
        n_bad++;
        $display("FAIL rnd%0d_result got %b want %b", i, res, e_res);
      end
      n_cmp++;
      if (abt !== e_abt) begin
        n_bad++;
        $display("FAIL rnd%0d_aborted got %b want %b", i, abt, e_abt);
      end
      n_cmp++;
      if (nld !== e_nld || nsh !== e_nsh) begin
        n_bad++;
        $display("FAIL rnd%0d_strobes got ld=%0d sh=%0d want %0d %0d",
                 i, nld, nsh, e_nld, e_nsh);
      end
      n_cmp++;
      if (perr !== 0) begin
        n_bad++;
        $display("FAIL rnd%0d_protocol got %0d errors want 0", i, perr);
      end
      mdl_val = e_res;
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_shift_right();
    test_shift_left();
    test_load_count0_held();
    test_abort_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
# shift_reg_sequencer

Command-driven controller for the team's bidirectional shift register: accepts one command at a time over a valid/ready handshake, then drives the register's load, shift-enable and direction controls for the required number of cycles. It sits between a host/CPU-side command source and a WIDTH-bit bidirectional shift register with zero fill. It reports completion with a one-cycle done pulse and a captured copy of the register contents.

## Interface
- WIDTH, 4, shift register data width
- CNT_W, 3, width of shift count (max 2^CNT_W-1 shifts per command)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE; command accepted on edge where cmd_valid & cmd_ready
- cmd_load  in  1  1 = perform one load cycle before shifting
- cmd_dir  in  1  0 = shift right, 1 = shift left
- cmd_count  in  CNT_W  number of shift cycles
- cmd_data  in  WIDTH  value to load when cmd_load=1
- abort  in  1  synchronous abort of the command in flight
- sr_load  out  1  register load strobe
- sr_en  out  1  register shift enable
- sr_dir  out  1  register shift direction
- sr_data  out  WIDTH  register parallel load value
- sr_q  in  WIDTH  register current contents
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle registered completion pulse
- aborted  out  1  valid with done; 1 if command ended by abort
- result  out  WIDTH  sr_q captured at completion; held until next completion

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1. On accept, latch cmd_load, cmd_dir, cmd_count, cmd_data. Next state: LOAD if cmd_load; else SHIFT if count!=0; else DONE.
- LOAD: one cycle; sr_load=1, sr_data=latched data. Next: SHIFT if count!=0, else DONE.
- SHIFT: sr_en=1, sr_dir=latched dir; remaining count decrements each cycle; after the last shift cycle -> DONE.
- DONE: one cycle; at its ending edge result <= sr_q, done <= 1 (pulse in following IDLE cycle), state -> IDLE.
- abort high in LOAD or SHIFT: sr_load and sr_en forced 0 that cycle, next state DONE, aborted <= 1 with the done pulse. abort ignored in IDLE and DONE.
- sr_data, sr_dir hold last latched values outside active states; sr_load, sr_en are 0 outside LOAD/SHIFT.
- cmd_valid while busy: ignored, no latching; the source must hold it until cmd_ready.
- Outputs decoded from state and latched registers only; the sole combinational input path is abort -> sr_load/sr_en.

## Timing
- Reset (async, immediate): state IDLE, cmd_ready=1, busy=0, sr_load=0, sr_en=0, sr_dir=0, sr_data=0, done=0, aborted=0, result=0, count=0.
- Accept in cycle c0: LOAD (if any) in c1; N shift cycles follow; DONE next; done=1 the cycle after DONE.
- Latency accept->done: L+N+2 cycles (L=1 if load). Load+N=1: done in c4. No load, N=0: done in c2.
- done cycle is IDLE: a new command may be accepted in the same cycle done=1 (back-to-back throughput L+N+2).
- Reset mid-command: all outputs to reset values at once; no done for the interrupted command.
- Count uses exactly CNT_W bits; no wrap; count=2^CNT_W-1 performs that many shifts.

## Test plan
- Reset then idle: all outputs at reset values, cmd_ready=1, busy=0; cmd_valid=0 for 5 cycles -> no activity.
- load 1010, dir right, count 1 -> sr_load 1 cycle in c1, sr_en 1 cycle in c2, done in c4, result=0101, aborted=0.
- From 0101, no load, dir left, count 2 -> two sr_en cycles with sr_dir=1, done in c4, result=0100.
- load 1011, count 0 -> single sr_load cycle, no sr_en, done in c3, result=1011; cmd_valid held during busy not accepted.
- load 1111, dir right, count 7, abort high in second SHIFT cycle -> exactly one shift, done with aborted=1, result=0111; next command accepted in the done cycle.
- reset pulsed during SHIFT of a count-5 command -> outputs reset immediately, no done; following load 0110 count 0 completes with result=0110.
